// File: rtl/biquad_filter.sv
// biquad_filter
//   Direct Form I biquad section built around a single time-shared 16x16
//   multiplier. Each accepted sample costs 7 clocks: capture, five MAC
//   steps, then output/history update.
//
//   State table
//     IDLE | waiting for pcm_valid; captures x[n] and all coefficients
//     MAC  | five multiply-accumulate steps: B0*x, B1*x1, B2*x2, -A1*y1, -A2*y2
//     OUT  | round, saturate, load d_out, pulse valid_out, shift history
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   pcm_valid  new-sample strobe (only honoured in IDLE)
//   d_in       input sample x[n], signed 16 bits
//   B0,B1,B2   feed-forward coefficients, Q2.14
//   A1,A2      feedback coefficients, Q2.14 (a0 = 1)
//   d_out      registered filtered sample y[n]
//   valid_out  one-cycle pulse when d_out is updated

module biquad_filter #(
    parameter int COEF_FRAC = 14,
    parameter int ACC_W     = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pcm_valid,
    input  logic signed [15:0] d_in,
    input  logic signed [15:0] B0,
    input  logic signed [15:0] B1,
    input  logic signed [15:0] B2,
    input  logic signed [15:0] A1,
    input  logic signed [15:0] A2,
    output logic signed [15:0] d_out,
    output logic               valid_out
);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) <<< (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN    = ~SAT_MAX;

    state_t state_q, state_d;
    logic [2:0] step_q;

    logic signed [15:0] x0_q, x1_q, x2_q, y1_q, y2_q;
    logic signed [15:0] b0_q, b1_q, b2_q, a1_q, a2_q;
    logic signed [ACC_W-1:0] acc_q;

    logic signed [15:0]      mul_a, mul_b;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_rnd, acc_shf;
    logic signed [15:0]      result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pcm_valid) state_d = MAC;
            MAC:     if (step_q == 3'd4) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand select for the shared multiplier, indexed by MAC step.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (step_q)
            3'd0: begin mul_a = b0_q; mul_b = x0_q; end
            3'd1: begin mul_a = b1_q; mul_b = x1_q; end
            3'd2: begin mul_a = b2_q; mul_b = x2_q; end
            3'd3: begin mul_a = a1_q; mul_b = y1_q; end
            3'd4: begin mul_a = a2_q; mul_b = y2_q; end
            default: begin mul_a = '0; mul_b = '0; end
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};

    // Round half toward +inf, then clamp to the 16-bit output range.
    assign acc_rnd = acc_q + ROUND_HALF;
    assign acc_shf = acc_rnd >>> COEF_FRAC;

    always_comb begin
        result = acc_shf[15:0];
        if (acc_shf > SAT_MAX)      result = 16'sh7fff;
        else if (acc_shf < SAT_MIN) result = 16'sh8000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q    <= '0;
            acc_q     <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            b0_q      <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
            a1_q      <= '0;
            a2_q      <= '0;
            d_out     <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pcm_valid) begin
                        x0_q   <= d_in;
                        b0_q   <= B0;
                        b1_q   <= B1;
                        b2_q   <= B2;
                        a1_q   <= A1;
                        a2_q   <= A2;
                        acc_q  <= '0;
                        step_q <= '0;
                    end
                end
                MAC: begin
                    // Steps 3 and 4 are the feedback terms, which subtract.
                    if (step_q < 3'd3) acc_q <= acc_q + prod_ext;
                    else               acc_q <= acc_q - prod_ext;
                    step_q <= step_q + 3'd1;
                end
                OUT: begin
                    d_out     <= result;
                    valid_out <= 1'b1;
                    x2_q      <= x1_q;
                    x1_q      <= x0_q;
                    y2_q      <= y1_q;
                    y1_q      <= result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_filter.sv
module tb_biquad_filter;

    logic               clk;
    logic               rst;
    logic               pcm_valid;
    logic signed [15:0] d_in;
    logic signed [15:0] B0, B1, B2, A1, A2;
    logic signed [15:0] d_out;
    logic               valid_out;

    int checks = 0;
    int errors = 0;

    biquad_filter #(.COEF_FRAC(14), .ACC_W(40)) dut (
        .clk       (clk),
        .rst       (rst),
        .pcm_valid (pcm_valid),
        .d_in      (d_in),
        .B0        (B0),
        .B1        (B1),
        .B2        (B2),
        .A1        (A1),
        .A2        (A2),
        .d_out     (d_out),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_coef(input int b0, input int b1, input int b2, input int a1, input int a2);
        B0 = 16'(b0); B1 = 16'(b1); B2 = 16'(b2); A1 = 16'(a1); A2 = 16'(a2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Strobe one sample and watch 8 edges: expect exactly one valid_out
    // pulse, 6 edges after the capture edge, carrying exp_y. When scramble
    // is set the coefficient ports are disturbed right after capture.
    task automatic sample(input int x, input int exp_y, input string tag, input bit scramble);
        int pulses;
        int lat;
        logic signed [15:0] sb0;
        pulses = 0;
        lat    = 0;
        sb0    = B0;
        @(negedge clk);
        d_in      = 16'(x);
        pcm_valid = 1'b1;
        @(posedge clk);
        #1;
        pcm_valid = 1'b0;
        if (scramble) begin
            B0 = 16'sh1234; B1 = 16'sh4321; A1 = 16'sh2000;
        end
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) begin
                pulses++;
                if (lat == 0) lat = i;
            end
        end
        if (scramble) begin
            B0 = sb0; B1 = 16'sd0; A1 = 16'sd0;
        end
        chk({tag, "_dout"}, int'(d_out), exp_y);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_latency"}, lat, 6);
    endtask

    initial begin
        int pulses;
        rst       = 1'b0;
        pcm_valid = 1'b0;
        d_in      = '0;
        set_coef(0, 0, 0, 0, 0);
        #12;
        chk("reset_dout", int'(d_out), 0);
        chk("reset_valid", int'(valid_out), 0);

        // Release reset together with a strobe: the first edge must capture.
        set_coef(16384, 0, 0, 0, 0);
        @(negedge clk);
        rst       = 1'b1;
        d_in      = 16'sd1000;
        pcm_valid = 1'b1;
        @(posedge clk);
        #1;
        pcm_valid = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) begin
                pulses++;
                chk("first_edge_latency", i, 6);
            end
        end
        chk("first_edge_pulses", pulses, 1);
        chk("first_edge_dout", int'(d_out), 1000);

        // Pass-through; second sample has the coefficient ports disturbed.
        sample(-1234, -1234, "pass_neg", 1'b1);
        chk("hold_dout", int'(d_out), -1234);

        // First-order recursion with step input.
        do_reset();
        set_coef(16384, 0, 0, -8192, 0);
        sample(1000, 1000, "rec0", 1'b0);
        sample(1000, 1500, "rec1", 1'b0);
        sample(1000, 1750, "rec2", 1'b0);

        // FIR history.
        do_reset();
        set_coef(16384, 16384, 16384, 0, 0);
        sample(100, 100, "fir0", 1'b0);
        sample(0,   100, "fir1", 1'b0);
        sample(0,   100, "fir2", 1'b0);
        sample(0,   0,   "fir3", 1'b0);

        // Rounding and saturation.
        do_reset();
        set_coef(8192, 0, 0, 0, 0);
        sample(3,  2,  "rnd_pos", 1'b0);
        sample(-3, -1, "rnd_neg", 1'b0);
        set_coef(32767, 0, 0, 0, 0);
        sample(30000,  32767,  "sat_pos", 1'b0);
        sample(-30000, -32768, "sat_neg", 1'b0);

        // Re-strobe during MAC is dropped and leaves history alone.
        do_reset();
        set_coef(16384, 16384, 0, 0, 0);
        sample(10, 10, "drop_pre", 1'b0);
        @(negedge clk);
        d_in      = 16'sd20;
        pcm_valid = 1'b1;
        @(posedge clk);
        #1;
        pcm_valid = 1'b0;
        @(posedge clk);
        #1;
        d_in      = 16'sd500;
        pcm_valid = 1'b1;
        @(posedge clk);
        #1;
        pcm_valid = 1'b0;
        pulses = 0;
        for (int i = 3; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) begin
                pulses++;
                chk("drop_latency", i, 6);
            end
        end
        chk("drop_pulses", pulses, 1);
        chk("drop_dout", int'(d_out), 30);
        sample(0, 20, "drop_hist", 1'b0);

        // Reset three cycles after capture aborts the sample.
        sample(700, 700, "abort_pre", 1'b0);
        @(negedge clk);
        d_in      = 16'sd300;
        pcm_valid = 1'b1;
        @(posedge clk);
        #1;
        pcm_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_dout", int'(d_out), 0);
        chk("abort_valid", int'(valid_out), 0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        sample(1000, 1000, "abort_post", 1'b0);
        sample(-1234, -234, "abort_post2", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/biquad_filter.md
BIQUAD_FILTER -- requirements
Module: biquad_filter

Interface
REQ-001 SHALL have parameter COEF_FRAC, default 14, meaning the number of fractional bits of every coefficient (Q2.14).
REQ-002 SHALL have parameter ACC_W, default 40, meaning the signed accumulator width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port pcm_valid, input, 1 bit: new-sample strobe.
REQ-006 SHALL have port d_in, input, signed 16 bits: input sample x[n].
REQ-007 SHALL have ports B0, B1, B2, input, signed 16 bits each: feed-forward coefficients, Q2.14.
REQ-008 SHALL have ports A1, A2, input, signed 16 bits each: feedback coefficients, Q2.14, with a0 normalized to 1.
REQ-009 SHALL have port d_out, output, signed 16 bits: filtered sample y[n], registered.
REQ-010 SHALL have port valid_out, output, 1 bit: one-cycle pulse marking an updated d_out.

Function
REQ-011 SHALL compute Direct Form I: y[n] = (B0*x[n] + B1*x[n-1] + B2*x[n-2] - A1*y[n-1] - A2*y[n-2]) >> COEF_FRAC.
REQ-012 SHALL form each product as full 32-bit signed and sign-extend it into the ACC_W accumulator; the accumulator SHALL not overflow for any 16-bit inputs.
REQ-013 SHALL round by adding 2^(COEF_FRAC-1) to the accumulator before an arithmetic right shift by COEF_FRAC (round half toward +infinity).
REQ-014 SHALL saturate the shifted result to the range -32768..32767 before it is used as d_out and as y[n-1].
REQ-015 SHALL use one time-shared multiplier, sequenced by an FSM with states IDLE, MAC, OUT.
REQ-016 In IDLE, when pcm_valid=1 at a rising edge, SHALL capture d_in and all five coefficients, clear the accumulator and go to MAC.
REQ-017 In MAC, SHALL perform exactly 5 multiply-accumulate steps on consecutive edges, in the order B0*x, B1*x1, B2*x2, -A1*y1, -A2*y2, then go to OUT.
REQ-018 In OUT, at one edge, SHALL:
  - load d_out with the saturated result;
  - set valid_out=1;
  - shift history: x2<=x1, x1<=x, y2<=y1, y1<=result;
  - return to IDLE.
REQ-019 valid_out SHALL be high for exactly one clock cycle; it is cleared on the following edge.
REQ-020 Latency: capture at edge k SHALL give d_out/valid_out updated at edge k+6; the next capture SHALL be possible at edge k+7 at the earliest.
REQ-021 SHALL ignore pcm_valid while in MAC or OUT; the sample is dropped and history is unchanged by it.
REQ-022 SHALL hold d_out at its last value between updates.
REQ-023 Coefficient port changes after capture SHALL NOT affect the sample in progress.

Reset
REQ-024 When rst=0, SHALL immediately, independent of clk, set d_out=0, valid_out=0, accumulator=0, x1=x2=y1=y2=0 and state=IDLE.
REQ-025 Reset asserted mid-computation SHALL abort that sample; no valid_out pulse SHALL occur for it.
REQ-026 After rst returns to 1, SHALL accept pcm_valid on the first rising edge.

Verification
REQ-027 Pass-through: B0=16384, others 0; x=1000, then x=-1234 -> d_out=1000, then -1234; each with a single valid_out pulse 6 cycles after its strobe.
REQ-028 Recursion: B0=16384, A1=-8192, others 0; step input 1000 held for 3 strobes -> d_out=1000, 1500, 1750.
REQ-029 FIR history: B0=B1=B2=16384, A=0; impulse 100, then 0, 0, 0 -> d_out=100, 100, 100, 0.
REQ-030 Rounding and saturation: B0=8192 with x=3 -> 2, and x=-3 -> -1; B0=32767 with x=30000 -> 32767, and x=-30000 -> -32768.
REQ-031 Control cases:
  - pcm_valid re-pulsed 2 cycles after a capture -> ignored, only one valid_out pulse;
  - rst=0 asserted 3 cycles after a capture -> no valid_out, d_out=0, history cleared; next impulse reproduces the REQ-027 response.
